// File: rtl/ball_motion_controller.sv
// ---------------------------------------------------------------------------
// ball_motion_controller
//
// Game-logic stage feeding the VGA generator. Owns the ball position and
// velocity, bounces it off the top, bottom and left walls and the paddle,
// and keeps saturating hit/miss scores. All motion happens once every
// STEP_DIV pixel clocks; every output is a register.
//
// Ports:
//   pixelClock  in   1   pixel clock, rising edge
//   reset       in   1   asynchronous, active-high
//   serve       in   1   level; launches the ball while IDLE
//   paddleTop   in  10   absolute top row of the paddle
//   ballX       out 10   ball left column
//   ballY       out 10   ball top row
//   ballVisible out  1   renderer paints the ball when 1
//   hitCount    out  8   paddle hits, saturating at 255
//   missCount   out  8   misses, saturating at 255
//   state       out  2   0=IDLE, 1=PLAY, 2=MISS
// ---------------------------------------------------------------------------
module ball_motion_controller #(
  parameter int H_VISIBLE = 1024,
  parameter int V_VISIBLE = 768,
  parameter int BORDER    = 16,
  parameter int BALL_SIZE = 16,
  parameter int PADDLE_X  = 976,
  parameter int PADDLE_H  = 96,
  parameter int SPEED     = 2,
  parameter int STEP_DIV  = 131072,
  parameter int MISS_HOLD = 64
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       serve,
  input  logic [9:0] paddleTop,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       ballVisible,
  output logic [7:0] hitCount,
  output logic [7:0] missCount,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2
  } stateT;

  localparam int DIV_W  = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int HOLD_W = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

  // Internal geometry is signed and one bit wider than strictly needed for
  // the candidate positions, so paddleTop+PADDLE_H cannot wrap even when
  // paddleTop is near its 10-bit maximum.
  localparam int AW = 12;

  localparam logic signed [AW-1:0] BORDER_S  = AW'(BORDER);
  localparam logic signed [AW-1:0] SPEED_S   = AW'(SPEED);
  localparam logic signed [AW-1:0] BALL_S    = AW'(BALL_SIZE);
  localparam logic signed [AW-1:0] BALL_M1_S = AW'(BALL_SIZE - 1);
  localparam logic signed [AW-1:0] YBOT_S    = AW'(V_VISIBLE - BORDER);
  localparam logic signed [AW-1:0] YMAX_S    = AW'(V_VISIBLE - BORDER - BALL_SIZE);
  localparam logic signed [AW-1:0] XRIGHT_S  = AW'(H_VISIBLE - BORDER);
  localparam logic signed [AW-1:0] PADX_S    = AW'(PADDLE_X);
  localparam logic signed [AW-1:0] PADH_S    = AW'(PADDLE_H);

  localparam logic [9:0] CENTRE_X   = 10'((H_VISIBLE - BORDER) / 2);
  localparam logic [9:0] CENTRE_Y   = 10'((V_VISIBLE - BORDER) / 2);
  localparam logic [9:0] BORDER_X   = 10'(BORDER);
  localparam logic [9:0] PAD_STOP_X = 10'(PADDLE_X - BALL_SIZE);

  stateT             stateQ, stateD;
  logic [9:0]        ballXQ, ballXD;
  logic [9:0]        ballYQ, ballYD;
  logic              visQ, visD;
  logic [7:0]        hitQ, hitD;
  logic [7:0]        missQ, missD;
  logic              dirXRightQ, dirXRightD;
  logic              dirYUpQ, dirYUpD;
  logic              toggleQ, toggleD;
  logic              serveFlagQ, serveFlagD;
  logic [HOLD_W-1:0] holdQ, holdD;
  logic [DIV_W-1:0]  divQ, divD;

  logic              stepStb;
  logic signed [AW-1:0] curX, curY, nx, ny, nyClamped, ptS;
  logic              hitTop, hitBottom, leftWall, paddleZone, overlap, missZone;

  assign stepStb = (divQ == DIV_W'(STEP_DIV - 1));

  // Candidate positions for this step and the collision tests derived
  // from them. The paddle overlap test uses the vertically clamped row.
  assign curX = signed'({2'b00, ballXQ});
  assign curY = signed'({2'b00, ballYQ});
  assign ptS  = signed'({2'b00, paddleTop});
  assign nx   = dirXRightQ ? (curX + SPEED_S) : (curX - SPEED_S);
  assign ny   = dirYUpQ    ? (curY - SPEED_S) : (curY + SPEED_S);

  assign hitTop    = dirYUpQ  && (ny < BORDER_S);
  assign hitBottom = !dirYUpQ && ((ny + BALL_S) > YBOT_S);
  assign nyClamped = hitTop ? BORDER_S : (hitBottom ? YMAX_S : ny);

  assign leftWall   = !dirXRightQ && (nx < BORDER_S);
  assign paddleZone = dirXRightQ && ((curX + BALL_S) < PADX_S) && ((nx + BALL_S) >= PADX_S);
  assign overlap    = (nyClamped <= (ptS + PADH_S)) && ((nyClamped + BALL_M1_S) >= ptS);
  assign missZone   = dirXRightQ && ((nx + BALL_S) >= XRIGHT_S);

  // Next-state logic: the divider free-runs, and the game state only
  // advances on the step strobe. The serve flag is tracked every cycle
  // while IDLE so a short serve pulse between steps is not lost.
  always_comb begin
    stateD     = stateQ;
    ballXD     = ballXQ;
    ballYD     = ballYQ;
    visD       = visQ;
    hitD       = hitQ;
    missD      = missQ;
    dirXRightD = dirXRightQ;
    dirYUpD    = dirYUpQ;
    toggleD    = toggleQ;
    serveFlagD = serveFlagQ;
    holdD      = holdQ;
    divD       = stepStb ? '0 : (divQ + DIV_W'(1));

    case (stateQ)
      IDLE: begin
        serveFlagD = serveFlagQ | serve;
        if (stepStb && serveFlagQ) begin
          // Launch without moving; alternate the vertical direction
          // from one serve to the next.
          stateD     = PLAY;
          dirXRightD = 1'b0;
          dirYUpD    = toggleQ;
          toggleD    = ~toggleQ;
          serveFlagD = 1'b0;
        end
      end

      PLAY: begin
        serveFlagD = 1'b0;
        if (stepStb) begin
          // Vertical motion applies on every step, including the one
          // where the ball is missed, and can combine with a horizontal
          // reflection.
          ballYD = nyClamped[9:0];
          if (hitTop) begin
            dirYUpD = 1'b0;
          end else if (hitBottom) begin
            dirYUpD = 1'b1;
          end

          if (leftWall) begin
            ballXD     = BORDER_X;
            dirXRightD = 1'b1;
          end else if (paddleZone && overlap) begin
            ballXD     = PAD_STOP_X;
            dirXRightD = 1'b0;
            hitD       = (hitQ == 8'hFF) ? hitQ : (hitQ + 8'd1);
          end else if (missZone) begin
            // Horizontal position is left where it was when missed.
            stateD = MISS;
            visD   = 1'b0;
            missD  = (missQ == 8'hFF) ? missQ : (missQ + 8'd1);
            holdD  = '0;
          end else begin
            ballXD = nx[9:0];
          end
        end
      end

      MISS: begin
        serveFlagD = 1'b0;
        if (stepStb) begin
          if (holdQ == HOLD_W'(MISS_HOLD - 1)) begin
            stateD = IDLE;
            ballXD = CENTRE_X;
            ballYD = CENTRE_Y;
            visD   = 1'b1;
            holdD  = '0;
          end else begin
            holdD = holdQ + HOLD_W'(1);
          end
        end
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // All state, including the divider and hold counter, returns to its
  // power-up value as soon as reset rises.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      stateQ     <= IDLE;
      ballXQ     <= CENTRE_X;
      ballYQ     <= CENTRE_Y;
      visQ       <= 1'b1;
      hitQ       <= 8'd0;
      missQ      <= 8'd0;
      dirXRightQ <= 1'b0;
      dirYUpQ    <= 1'b0;
      toggleQ    <= 1'b0;
      serveFlagQ <= 1'b0;
      holdQ      <= '0;
      divQ       <= '0;
    end else begin
      stateQ     <= stateD;
      ballXQ     <= ballXD;
      ballYQ     <= ballYD;
      visQ       <= visD;
      hitQ       <= hitD;
      missQ      <= missD;
      dirXRightQ <= dirXRightD;
      dirYUpQ    <= dirYUpD;
      toggleQ    <= toggleD;
      serveFlagQ <= serveFlagD;
      holdQ      <= holdD;
      divQ       <= divD;
    end
  end

  assign ballX       = ballXQ;
  assign ballY       = ballYQ;
  assign ballVisible = visQ;
  assign hitCount    = hitQ;
  assign missCount   = missQ;
  assign state       = stateQ;

endmodule

// File: tb/tb_ball_motion_controller.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_controller
//
// Directed bench for ball_motion_controller with STEP_DIV shrunk to 4 so a
// motion step lands on every 4th rising edge after reset is released. A
// table of {wait, serve, paddleTop, expected outputs} records walks one
// full rally (wall bounces, paddle hit, miss, hold, relaunch upward);
// hand-written sequences then cover asynchronous reset in PLAY and MISS
// and the divider restart.
// ---------------------------------------------------------------------------
module tb_ball_motion_controller;

  logic       pixelClock = 1'b0;
  logic       reset;
  logic       serve;
  logic [9:0] paddleTop;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic       ballVisible;
  logic [7:0] hitCount;
  logic [7:0] missCount;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         waitSteps;
    bit         doServe;
    logic [9:0] pad;
    logic [9:0] expX;
    logic [9:0] expY;
    logic       expVis;
    logic [7:0] expHit;
    logic [7:0] expMiss;
    logic [1:0] expState;
  } vecT;

  vecT vecs[$];

  ball_motion_controller #(
    .STEP_DIV(4)
  ) dut (
    .pixelClock (pixelClock),
    .reset      (reset),
    .serve      (serve),
    .paddleTop  (paddleTop),
    .ballX      (ballX),
    .ballY      (ballY),
    .ballVisible(ballVisible),
    .hitCount   (hitCount),
    .missCount  (missCount),
    .state      (state)
  );

  // 10 ns pixel clock.
  always #5 pixelClock = ~pixelClock;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input int w, input bit s, input int pad, input int x, input int y,
                        input int vis, input int hit, input int miss, input int st);
    vecT v;
    v.waitSteps = w;
    v.doServe   = s;
    v.pad       = 10'(pad);
    v.expX      = 10'(x);
    v.expY      = 10'(y);
    v.expVis    = 1'(vis);
    v.expHit    = 8'(hit);
    v.expMiss   = 8'(miss);
    v.expState  = 2'(st);
    vecs.push_back(v);
  endtask

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int x, input int y, input int vis,
                             input int hit, input int miss, input int st);
    checkField({tag, ".state"},       32'(state),       32'(st));
    checkField({tag, ".ballX"},       32'(ballX),       32'(x));
    checkField({tag, ".ballY"},       32'(ballY),       32'(y));
    checkField({tag, ".ballVisible"}, 32'(ballVisible), 32'(vis));
    checkField({tag, ".hitCount"},    32'(hitCount),    32'(hit));
    checkField({tag, ".missCount"},   32'(missCount),   32'(miss));
  endtask

  // Called right after a step edge (+1 ns); returns right after the step
  // edge n steps later.
  task automatic waitSteps(input int n);
    repeat (4 * n) @(posedge pixelClock);
    #1;
  endtask

  // Optional one-cycle serve pulse, then advance to the requested step.
  task automatic applyStimulus(input vecT v);
    paddleTop = v.pad;
    if (v.doServe) begin
      serve = 1'b1;
      @(posedge pixelClock);
      #1;
      serve = 1'b0;
      repeat (4 * v.waitSteps - 1) @(posedge pixelClock);
      #1;
    end else begin
      waitSteps(v.waitSteps);
    end
  endtask

  // Asynchronous reset pulse between edges, checked before any edge occurs,
  // then released just after an edge so the next edge is divider edge 1.
  task automatic asyncReset(input string tag);
    repeat (2) @(posedge pixelClock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput(tag, 504, 376, 1, 0, 0, 0);
    @(posedge pixelClock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Trajectory notes, t = movement steps since launch:
    // x falls 2/step from 504 to 16 at t=244, clamps at t=245, then
    // rises to 958 at t=716 and hits the paddle at t=717 (ny=366, paddle
    // rows 381..477 touch the ball's bottom row 381). y reaches 736 at
    // t=180, clamps at 181, falls to 16 at 541, clamps at 542.
    addVec(0,   0, 381, 504, 376, 1, 0, 0, 0);
    addVec(5,   0, 381, 504, 376, 1, 0, 0, 0);
    addVec(1,   1, 381, 504, 376, 1, 0, 0, 1);
    addVec(1,   0, 381, 502, 378, 1, 0, 0, 1);
    addVec(179, 0, 381, 144, 736, 1, 0, 0, 1);
    addVec(1,   0, 381, 142, 736, 1, 0, 0, 1);
    addVec(1,   0, 381, 140, 734, 1, 0, 0, 1);
    addVec(62,  0, 381, 16,  610, 1, 0, 0, 1);
    addVec(1,   0, 381, 16,  608, 1, 0, 0, 1);
    addVec(1,   0, 381, 18,  606, 1, 0, 0, 1);
    addVec(295, 0, 381, 608, 16,  1, 0, 0, 1);
    addVec(1,   0, 381, 610, 16,  1, 0, 0, 1);
    addVec(1,   0, 381, 612, 18,  1, 0, 0, 1);
    addVec(173, 0, 381, 958, 364, 1, 0, 0, 1);
    addVec(1,   0, 381, 960, 366, 1, 1, 0, 1);
    // After the hit: left wall at t=1190 (y=162), back at the paddle at
    // t=1662 with ny=662. Paddle 565 covers rows up to 661: just misses.
    addVec(1,   0, 565, 958, 368, 1, 1, 0, 1);
    addVec(472, 0, 565, 16,  162, 1, 1, 0, 1);
    addVec(472, 0, 565, 960, 662, 1, 1, 0, 1);
    addVec(15,  0, 565, 990, 632, 1, 1, 0, 1);
    addVec(1,   0, 565, 990, 630, 0, 1, 1, 2);
    // Serve during MISS is ignored; 63 more steps still in MISS, the 64th
    // returns to IDLE, and the ball stays put until a fresh serve.
    addVec(63,  1, 565, 990, 630, 0, 1, 1, 2);
    addVec(1,   0, 565, 504, 376, 1, 1, 1, 0);
    addVec(3,   0, 565, 504, 376, 1, 1, 1, 0);
    addVec(1,   1, 565, 504, 376, 1, 1, 1, 1);
    addVec(1,   0, 565, 502, 374, 1, 1, 1, 1);

    reset     = 1'b1;
    serve     = 1'b0;
    paddleTop = 10'd381;
    repeat (2) @(posedge pixelClock);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].expX), int'(vecs[i].expY),
                  int'(vecs[i].expVis), int'(vecs[i].expHit), int'(vecs[i].expMiss),
                  int'(vecs[i].expState));
    end

    // Reset in the middle of PLAY, then confirm the divider restarted:
    // serve lands on edge 1, launch happens exactly on edge 4.
    asyncReset("rstPlay");
    serve = 1'b1;
    @(posedge pixelClock);
    #1;
    serve = 1'b0;
    repeat (2) @(posedge pixelClock);
    #1;
    checkOutput("divEdge3", 504, 376, 1, 0, 0, 0);
    @(posedge pixelClock);
    #1;
    checkOutput("divEdge4", 504, 376, 1, 0, 0, 1);

    // Toggle was reset, so this rally repeats the first one; with the
    // paddle at 16..112 the ball slides past and is missed at t=733.
    paddleTop = 10'd16;
    waitSteps(716);
    checkOutput("run2t716", 958, 364, 1, 0, 0, 1);
    waitSteps(1);
    checkOutput("run2t717", 960, 366, 1, 0, 0, 1);
    waitSteps(15);
    checkOutput("run2t732", 990, 396, 1, 0, 0, 1);
    waitSteps(1);
    checkOutput("run2t733", 990, 398, 0, 0, 1, 2);
    waitSteps(10);
    checkOutput("run2hold", 990, 398, 0, 0, 1, 2);

    asyncReset("rstMiss");
    waitSteps(3);
    checkOutput("postRst", 504, 376, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
